// File: rtl/i2c_pkg.sv
// Shared I2C definitions: arbiter state encoding, default field widths,
// and the state codes used by the I2C master FSM.
package i2c_pkg;

    localparam int ADDR_LEN_DEF = 7;
    localparam int DATA_LEN_DEF = 8;

    // Transaction arbiter states
    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ISSUE = 3'd1,
        ARB_START = 3'd2,
        ARB_WAIT  = 3'd3,
        ARB_RESP  = 3'd4
    } arb_state_t;

    // Master FSM states (shared with the master/SCL generator)
    typedef enum logic [2:0] {
        M_IDLE  = 3'd0,
        M_START = 3'd1,
        M_ADDR  = 3'd2,
        M_DATA  = 3'd3,
        M_ACK   = 3'd4,
        M_STOP  = 3'd5
    } m_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request searching upward
// from the pointer, wrapping at NUM_REQ-1 back to 0.
module rr_pick
    import i2c_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_win,
    output logic               o_any
);

    logic [PTR_W-1:0] w_idx;

    // Walk all slots starting at the pointer; the first hit wins
    always_comb begin
        o_win = '0;
        o_any = 1'b0;
        w_idx = i_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                o_any        = 1'b1;
            end
            w_idx = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin transaction arbiter sharing one I2C master among NUM_REQ
// requesters. Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_LEN       = ADDR_LEN_DEF,
    parameter int DATA_LEN       = DATA_LEN_DEF,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_LEN-1:0]          rsp_rdata,
    output logic                         rsp_err,
    output logic                         arb_busy,
    output logic                         m_start,
    output logic [ADDR_LEN-1:0]          m_addr,
    output logic                         m_rw,
    output logic [DATA_LEN-1:0]          m_wdata,
    output logic                         m_abort,
    input  logic                         m_busy,
    input  logic                         m_done,
    input  logic [DATA_LEN-1:0]          m_rdata,
    input  logic                         m_nack
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t            r_state;
    arb_state_t            w_next;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_idx;
    logic [NUM_REQ-1:0]    r_grant;
    logic [ADDR_LEN-1:0]   r_addr;
    logic                  r_rw;
    logic [DATA_LEN-1:0]   r_wdata;
    logic [DATA_LEN-1:0]   r_rdata;
    logic                  r_err;

    logic [NUM_REQ-1:0]    w_win;
    logic                  w_any;
    logic [PTR_W-1:0]      w_sel_idx;
    logic [ADDR_LEN-1:0]   w_sel_addr;
    logic                  w_sel_rw;
    logic [DATA_LEN-1:0]   w_sel_wdata;
    logic                  w_timeout;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    // Select the winner's index and payload from the packed request buses
    always_comb begin
        w_sel_idx   = '0;
        w_sel_addr  = '0;
        w_sel_rw    = 1'b0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_sel_idx   = PTR_W'(i);
                w_sel_addr  = req_addr[i*ADDR_LEN +: ADDR_LEN];
                w_sel_rw    = req_rw[i];
                w_sel_wdata = req_wdata[i*DATA_LEN +: DATA_LEN];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_abort;

    // The last WAIT cycle before the limit; m_done still takes priority
    assign w_timeout = (r_state == ARB_WAIT) && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: zero outside WAIT, so it starts at 0 on WAIT entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd    <= '0;
            r_abort <= 1'b0;
        end else begin
            r_wd    <= (r_state == ARB_WAIT) ? r_wd + 1'b1 : '0;
            r_abort <= w_timeout && !m_done;
        end
    end

    assign m_abort = r_abort;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
    assign m_abort          = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:  if (w_any) w_next = ARB_ISSUE;
            ARB_ISSUE: if (!m_busy) w_next = ARB_START;
            ARB_START: w_next = ARB_WAIT;
            ARB_WAIT:  if (m_done || w_timeout) w_next = ARB_RESP;
            ARB_RESP:  w_next = ARB_IDLE;
            default:   w_next = ARB_IDLE;
        endcase
    end

    // Ownership, payload latch, result capture and pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_idx   <= '0;
            r_grant <= '0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_idx   <= w_sel_idx;
                        r_addr  <= w_sel_addr;
                        r_rw    <= w_sel_rw;
                        r_wdata <= w_sel_wdata;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ARB_WAIT: begin
                    if (m_done) begin
                        // Read data is only meaningful on a clean read
                        r_err   <= m_nack;
                        r_rdata <= (r_rw && !m_nack) ? m_rdata : '0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                ARB_RESP: begin
                    r_grant <= '0;
                    r_ptr   <= (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grant     = r_grant;
    assign arb_busy  = (r_state != ARB_IDLE);
    assign m_start   = (r_state == ARB_START);
    assign m_addr    = r_addr;
    assign m_rw      = r_rw;
    assign m_wdata   = r_wdata;
    assign rsp_valid = (r_state == ARB_RESP) ? r_grant : '0;
    assign rsp_err   = (r_state == ARB_RESP) && r_err;
    assign rsp_rdata = (r_state == ARB_RESP) ? r_rdata : '0;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Table-driven bench for i2c_txn_arbiter plus hand-written multi-cycle cases.
module tb_i2c_txn_arbiter;

    localparam int NR = 4;
    localparam int AL = 7;
    localparam int DL = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*AL-1:0] req_addr;
    logic [NR-1:0]    req_rw;
    logic [NR*DL-1:0] req_wdata;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    rsp_valid;
    logic [DL-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             arb_busy;
    logic             m_start;
    logic [AL-1:0]    m_addr;
    logic             m_rw;
    logic [DL-1:0]    m_wdata;
    logic             m_abort;
    logic             m_busy;
    logic             m_done;
    logic [DL-1:0]    m_rdata;
    logic             m_nack;

    int total = 0;
    int bad   = 0;

    logic [AL-1:0] sa [NR];
    logic [DL-1:0] sw [NR];

    typedef struct {
        logic [NR-1:0] reqv;
        logic [NR-1:0] rwv;
        int            win;
        logic          nack;
        logic [DL-1:0] rd;
        logic          err;
        logic [DL-1:0] erd;
    } vec_t;

    vec_t vt [15];

    i2c_txn_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_LEN       (AL),
        .DATA_LEN       (DL),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_wdata (req_wdata),
        .grant     (grant),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .arb_busy  (arb_busy),
        .m_start   (m_start),
        .m_addr    (m_addr),
        .m_rw      (m_rw),
        .m_wdata   (m_wdata),
        .m_abort   (m_abort),
        .m_busy    (m_busy),
        .m_done    (m_done),
        .m_rdata   (m_rdata),
        .m_nack    (m_nack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One transaction from an IDLE cycle with req already driven, m_busy low
    task automatic run_txn(input int idx, input logic [NR-1:0] rwv, input logic nack,
                           input logic [DL-1:0] rd, input logic eerr, input logic [DL-1:0] erd);
        logic [NR-1:0] oh;
        oh = NR'(1) << idx;
        tick();
        chk("grant", 32'(grant), 32'(oh));
        chk("issue_busy", 32'(arb_busy), 32'd1);
        chk("issue_nostart", 32'(m_start), 32'd0);
        chk("issue_norsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("start", 32'(m_start), 32'd1);
        chk("m_addr", 32'(m_addr), 32'(sa[idx]));
        chk("m_wdata", 32'(m_wdata), 32'(sw[idx]));
        chk("m_rw", 32'(m_rw), 32'(rwv[idx]));
        tick();
        chk("wait_nostart", 32'(m_start), 32'd0);
        m_done  = 1'b1;
        m_rdata = rd;
        m_nack  = nack;
        tick();
        m_done  = 1'b0;
        m_rdata = '0;
        m_nack  = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(erd));
        chk("resp_grant", 32'(grant), 32'(oh));
        tick();
        chk("idle_rsp", 32'(rsp_valid), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_busy", 32'(arb_busy), 32'd0);
    endtask

    initial begin
        sa = '{7'h10, 7'h21, 7'h50, 7'h63};
        sw = '{8'h11, 8'h22, 8'hA5, 8'h33};
        vt[0]  = '{4'b0100, 4'b0000, 2, 1'b0, 8'h77, 1'b0, 8'h00};
        vt[1]  = '{4'b0010, 4'b0010, 1, 1'b1, 8'h3C, 1'b1, 8'h00};
        vt[2]  = '{4'b0010, 4'b0010, 1, 1'b0, 8'h3C, 1'b0, 8'h3C};
        vt[3]  = '{4'b1000, 4'b0000, 3, 1'b0, 8'hFF, 1'b0, 8'h00};
        vt[4]  = '{4'b1111, 4'b0101, 0, 1'b0, 8'h5A, 1'b0, 8'h5A};
        vt[5]  = '{4'b1111, 4'b0101, 1, 1'b0, 8'h11, 1'b0, 8'h00};
        vt[6]  = '{4'b1111, 4'b0101, 2, 1'b0, 8'hC3, 1'b0, 8'hC3};
        vt[7]  = '{4'b1111, 4'b0101, 3, 1'b0, 8'h99, 1'b0, 8'h00};
        vt[8]  = '{4'b1111, 4'b0101, 0, 1'b1, 8'h01, 1'b1, 8'h00};
        vt[9]  = '{4'b1111, 4'b0101, 1, 1'b0, 8'h22, 1'b0, 8'h00};
        vt[10] = '{4'b1111, 4'b0101, 2, 1'b0, 8'h80, 1'b0, 8'h80};
        vt[11] = '{4'b1111, 4'b0101, 3, 1'b0, 8'h44, 1'b0, 8'h00};
        vt[12] = '{4'b1010, 4'b0000, 1, 1'b0, 8'h00, 1'b0, 8'h00};
        vt[13] = '{4'b1001, 4'b1000, 3, 1'b0, 8'hE7, 1'b0, 8'hE7};
        vt[14] = '{4'b1001, 4'b0000, 0, 1'b0, 8'h00, 1'b0, 8'h00};

        for (int i = 0; i < NR; i++) begin
            req_addr[i*AL +: AL]  = sa[i];
            req_wdata[i*DL +: DL] = sw[i];
        end
        rst_n   = 1'b0;
        req     = '0;
        req_rw  = '0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_rdata = '0;
        m_nack  = 1'b0;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(arb_busy), 32'd0);
        chk("rst_start", 32'(m_start), 32'd0);
        chk("rst_abort", 32'(m_abort), 32'd0);
        chk("rst_maddr", 32'(m_addr), 32'd0);
        chk("rst_mwdata", 32'(m_wdata), 32'd0);
        chk("rst_rdata_err", 32'({rsp_rdata, rsp_err}), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            req    = vt[i].reqv;
            req_rw = vt[i].rwv;
            run_txn(vt[i].win, vt[i].rwv, vt[i].nack, vt[i].rd, vt[i].err, vt[i].erd);
        end

        // Busy master: grant held, start waits until the cycle after m_busy falls
        req    = 4'b0001;
        req_rw = 4'b0000;
        m_busy = 1'b1;
        tick();
        chk("busy_grant", 32'(grant), 32'h1);
        req = 4'b0100;
        for (int i = 0; i < 9; i++) begin
            m_done = (i == 3);
            m_nack = (i == 3);
            tick();
            chk("busy_hold", 32'({m_start, rsp_valid, grant}), 32'h01);
        end
        m_done = 1'b0;
        m_nack = 1'b0;
        m_busy = 1'b0;
        tick();
        chk("busy_start", 32'({m_start, grant}), 32'h11);
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("busy_rsp", 32'({rsp_valid, rsp_err}), 32'h2);
        req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("withdraw_idle", 32'({grant, arb_busy}), 32'd0);
        end

        // Reset in WAIT drops the transaction and returns the pointer to 0
        req = 4'b1000;
        tick();
        chk("mid_grant", 32'(grant), 32'h8);
        tick();
        tick();
        req = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 32'({grant, arb_busy, m_start, rsp_valid}), 32'd0);
        chk("mid_rst_payload", 32'({m_addr, m_wdata, m_rw}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_norsp", 32'({rsp_valid, grant}), 32'd0);
        req = 4'b1111;
        run_txn(0, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00);
        req = 4'b1000;
        run_txn(3, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00);
        req = '0;

`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int n;
            req = 4'b0100;
            tick();
            tick();
            tick();
            req = '0;
            n = 0;
            while (!m_abort && n < 40) begin
                tick();
                n++;
            end
            chk("timeout_cycles", 32'(n), 32'd16);
            chk("timeout_rsp", 32'({rsp_valid, rsp_err}), 32'h9);
            tick();
            chk("abort_pulse", 32'({m_abort, rsp_valid}), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
